fwd_hazard_ctrl: RTL and testbench

- Forwarding and load-use hazard controller for the 5-stage 64-bit pipelined CPU.
- Drives the 2-bit selects of the two EX-stage operand 4:1 muxes: regfile, EX/MEM result, MEM/WB result, or zero.
- Keeps its own shadow pipeline of destination-register metadata for the EX, MEM and WB stages.
- Raises a one-cycle stall on load-use hazards and honours a flush from branch resolution.

---
 rtl/fwd_pkg.sv | 30 +++
 rtl/fwd_src_sel.sv | 52 +++++
 rtl/fwd_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared types and constants for the forwarding / load-use
//             hazard controller. Holds the operand-mux select encoding and
//             the per-stage destination metadata record.
//  Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    // Default register index width and XZR index.
    localparam int unsigned REG_W_DEF    = 5;
    localparam int unsigned ZERO_REG_DEF = 31;

    // EX-stage operand mux select encoding.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_ZERO  = 2'b11;

    // Destination-register metadata carried by each shadow stage.
    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } stage_meta_t;

endpackage
`default_nettype wire

// File: rtl/fwd_src_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_src_sel
//  Purpose  : Combinational forwarding select for one EX operand.
//             XZR reads zero; otherwise the newest producer (EX before MEM)
//             wins; anything else reads the register file.
//  Ports    : src/uses           - source register and whether it is read
//             ex_*/mem_*         - EX and MEM shadow entry fields
//             sel                - 2-bit operand mux select
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    output logic [1:0]       sel
);

    localparam logic [REG_W-1:0] C_ZERO = REG_W'(ZERO_REG);

    logic w_ex_writer;
    logic w_mem_writer;

    // A write to XZR is discarded, so it is never a forwarding source.
    assign w_ex_writer  = ex_valid  & ex_regwrite  & (ex_rd  != C_ZERO);
    assign w_mem_writer = mem_valid & mem_regwrite & (mem_rd != C_ZERO);

    always_comb begin
        sel = FWD_REG;
        if (!uses) begin
            sel = FWD_REG;
        end else if (src == C_ZERO) begin
            sel = FWD_ZERO;
        end else if (w_ex_writer && (ex_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (w_mem_writer && (mem_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : Forwarding and load-use hazard controller for the 5-stage
//             pipeline. Tracks EX/MEM/WB destination metadata, registers the
//             EX operand mux selects and raises a one-cycle load-use stall.
//  Ports    : clk, reset (async, active-high)
//             id_*        - decoded ID-stage instruction fields
//             flush       - squash the ID instruction
//             fwd_a_sel   - operand A select, valid during EX
//             fwd_b_sel   - operand B select, valid during EX
//             stall       - combinational hold of PC and IF/ID
//             stall_count - saturating count of stall cycles
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_W-1:0] C_ZERO = REG_W'(ZERO_REG);

    stage_meta_t      r_ex;
    stage_meta_t      r_mem;
    stage_meta_t      r_wb;   // visibility only: regfile is write-before-read
    logic [1:0]       r_fwd_a_sel;
    logic [1:0]       r_fwd_b_sel;
    logic [CNT_W-1:0] r_stall_count;

    logic [1:0]       w_a_sel;
    logic [1:0]       w_b_sel;
    logic             w_load_hit;
    logic             w_stall;
    logic             w_bubble;

    fwd_src_sel #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_sel_a (
        .src          (id_rn),
        .uses         (id_uses_rn),
        .ex_valid     (r_ex.valid),
        .ex_rd        (r_ex.rd),
        .ex_regwrite  (r_ex.regwrite),
        .mem_valid    (r_mem.valid),
        .mem_rd       (r_mem.rd),
        .mem_regwrite (r_mem.regwrite),
        .sel          (w_a_sel)
    );

    fwd_src_sel #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_sel_b (
        .src          (id_rm),
        .uses         (id_uses_rm),
        .ex_valid     (r_ex.valid),
        .ex_rd        (r_ex.rd),
        .ex_regwrite  (r_ex.regwrite),
        .mem_valid    (r_mem.valid),
        .mem_rd       (r_mem.rd),
        .mem_regwrite (r_mem.regwrite),
        .sel          (w_b_sel)
    );

    // A load in EX only has its data at the end of MEM, so a dependent
    // instruction in ID must wait one cycle and then pick it up from MEM/WB.
    assign w_load_hit = r_ex.valid & r_ex.memread & r_ex.regwrite
                      & (r_ex.rd != C_ZERO)
                      & ((id_uses_rn & (id_rn == r_ex.rd))
                       | (id_uses_rm & (id_rm == r_ex.rd)));

    // Flush wins over stall: the dependent instruction is being squashed.
    assign w_stall  = ~reset & id_valid & ~flush & w_load_hit;
    assign w_bubble = flush | w_stall | ~id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_fwd_a_sel   <= FWD_REG;
            r_fwd_b_sel   <= FWD_REG;
            r_stall_count <= '0;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_bubble) begin
                r_ex        <= '0;
                r_fwd_a_sel <= FWD_REG;
                r_fwd_b_sel <= FWD_REG;
            end else begin
                r_ex.valid    <= 1'b1;
                r_ex.rd       <= id_rd;
                r_ex.regwrite <= id_regwrite;
                r_ex.memread  <= id_memread;
                r_fwd_a_sel   <= w_a_sel;
                r_fwd_b_sel   <= w_b_sel;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    // The WB entry is always last cycle's MEM entry.
    a_wb_follows_mem : assert property (
        @(posedge clk) disable iff (reset) r_wb == $past(r_mem)
    );

    assign fwd_a_sel   = r_fwd_a_sel;
    assign fwd_b_sel   = r_fwd_b_sel;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Purpose  : Directed vector bench for fwd_hazard_ctrl. The counter width is
//             narrowed so saturation is reachable in a few stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    int n_checks;
    int n_errors;

    fwd_hazard_ctrl #(
        .REG_W    (5),
        .ZERO_REG (31),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rn  (id_uses_rn),
        .id_uses_rm  (id_uses_rm),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rn;
        logic       urn;
        logic [4:0] rm;
        logic       urm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       exp_stall;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic v,
                                input int rn, input logic urn,
                                input int rm, input logic urm,
                                input int rd, input logic rw, input logic mr,
                                input logic fl, input logic es,
                                input logic [1:0] ea, input logic [1:0] eb,
                                input logic [1:0] ec);
        vec_t t;
        t.name = nm; t.v = v;
        t.rn = 5'(rn); t.urn = urn; t.rm = 5'(rm); t.urm = urm;
        t.rd = 5'(rd); t.rw = rw; t.mr = mr; t.fl = fl;
        t.exp_stall = es; t.exp_a = ea; t.exp_b = eb; t.exp_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive ID, check the combinational
    // stall mid-cycle, then check the registered selects and counter.
    task automatic apply(input vec_t t);
        id_valid    = t.v;
        id_rn       = t.rn;
        id_uses_rn  = t.urn;
        id_rm       = t.rm;
        id_uses_rm  = t.urm;
        id_rd       = t.rd;
        id_regwrite = t.rw;
        id_memread  = t.mr;
        flush       = t.fl;
        #2;
        chk({t.name, ".stall"}, 32'(stall), 32'(t.exp_stall));
        @(posedge clk);
        #1;
        chk({t.name, ".a_sel"}, 32'(fwd_a_sel), 32'(t.exp_a));
        chk({t.name, ".b_sel"}, 32'(fwd_b_sel), 32'(t.exp_b));
        chk({t.name, ".cnt"}, 32'(stall_count), 32'(t.exp_cnt));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        id_valid = 1'b0; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0;
        id_uses_rm = 1'b0; id_rd = '0; id_regwrite = 1'b0;
        id_memread = 1'b0; flush = 1'b0;

        //          name          v  rn urn rm urm rd rw mr fl st  a      b      cnt
        vecs.push_back(mk("nop0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("add_x1",    1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("add_fwd_a", 1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 2'b01, 2'b00, 2'd0));
        vecs.push_back(mk("add_x1b",   1,10, 1,11, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("nop1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("sub_fwd_b", 1, 5, 1, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b10, 2'd0));
        vecs.push_back(mk("add_x1c",   1,12, 1,13, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("add_x1d",   1,12, 1,13, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("orr_newest",1, 1, 1, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b01, 2'd0));
        vecs.push_back(mk("ldur_x7",   1,20, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0));
        vecs.push_back(mk("add_stall", 1, 7, 1, 9, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("add_retry", 1, 7, 1, 9, 1, 8, 1, 0, 0, 0, 2'b10, 2'b00, 2'd1));
        vecs.push_back(mk("x31_src",   1,31, 1, 8, 1,10, 1, 0, 0, 0, 2'b11, 2'b01, 2'd1));
        vecs.push_back(mk("x31_wr",    1, 1, 1, 2, 1,31, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("rd_x31",    1,31, 1, 4, 1, 3, 1, 0, 0, 0, 2'b11, 2'b00, 2'd1));
        vecs.push_back(mk("ldur_x31",  1, 5, 1, 0, 0,31, 1, 1, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("use_x31",   1,31, 1,31, 1, 9, 1, 0, 0, 0, 2'b11, 2'b11, 2'd1));
        vecs.push_back(mk("unused_src",1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("ldur_x7b",  1,20, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("flush_add", 1, 7, 1, 9, 1, 8, 1, 0, 1, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("post_flush",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("ldur_x5",   1,20, 1, 0, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 2'd1));
        vecs.push_back(mk("stall_rm",  1, 2, 1, 5, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 2'd2));
        vecs.push_back(mk("retry_rm",  1, 2, 1, 5, 1, 6, 1, 0, 0, 0, 2'b00, 2'b10, 2'd2));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.a_sel", 32'(fwd_a_sel), 32'd0);
        chk("rst.b_sel", 32'(fwd_b_sel), 32'd0);
        chk("rst.cnt", 32'(stall_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Counter saturation: two more load-use pairs, ceiling is 3.
        for (int p = 0; p < 2; p++) begin
            apply(mk("sat_ldur", 1,20, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, (p == 0) ? 2'd2 : 2'd3));
            apply(mk("sat_stall",1, 7, 1, 9, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 2'd3));
            apply(mk("sat_retry",1, 7, 1, 9, 1, 8, 1, 0, 0, 0, 2'b10, 2'b00, 2'd3));
        end

        // Reset in the middle of a stall; pre-reset writer must be forgotten.
        apply(mk("pre_add_x1", 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd3));
        apply(mk("pre_ldur",   1,20, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 2'd3));
        id_valid = 1'b1; id_rn = 5'd7; id_uses_rn = 1'b1; id_rm = 5'd9;
        id_uses_rm = 1'b1; id_rd = 5'd8; id_regwrite = 1'b1;
        id_memread = 1'b0; flush = 1'b0;
        #2;
        chk("midrst.stall_before", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst.stall", 32'(stall), 32'd0);
        chk("midrst.a_sel", 32'(fwd_a_sel), 32'd0);
        chk("midrst.b_sel", 32'(fwd_b_sel), 32'd0);
        chk("midrst.cnt", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(mk("post_rst_x1", 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard bound in case the clock or a wait never completes.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
